nd_b10_updown_counter: RTL and testbench
========================================

# nd_b10_updown_counter

Parametrised N-digit BCD (base-10) counter: up/down count, synchronous parallel load, and a selectable wrap or saturate mode at the range limits. It provides a combinational terminal carry/borrow output so instances can be cascaded to count more digits. It replaces fixed four-digit up-only counter chains in display, timer and event-count datapaths.

## Interface

Parameters:
- N_DIGITS, default 4: number of BCD digits; legal range 1..8.
- SATURATE, default 0: 0 = wrap at the range limits; 1 = hold at the range limits.

Ports (the block uses one clock; reset is synchronous and active-high):
- clock  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-high; clears all state.
- ei  in  1  count enable (carry/borrow in when cascaded).
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous parallel load of d.
- d  in  4*N_DIGITS  load value; digit k is d[4k+3:4k], digit 0 is least significant.
- q  out  4*N_DIGITS  registered count, same digit layout as d.
- eu  out  1  combinational terminal carry/borrow out.
- load_err  out  1  registered one-cycle flag: the last load contained an invalid digit.

## Operation

- Priority at each rising edge: reset, then load, then count (ei), then hold.
- Reset: q is set to 0 and load_err is set to 0.
- Load:
  - Each digit of d that is ≤ 9 is stored unchanged.
  - Each digit of d that is > 9 is stored as 0.
  - load_err is set to 1 for the next cycle if any digit was > 9, otherwise 0.
  - ei is ignored in a load cycle.
- Count up (ei=1, up=1), per digit:
  - Digit 0 increments.
  - A digit at 9 with a carry in becomes 0 and carries into the next digit.
- Count down (ei=1, up=0), per digit:
  - Digit 0 decrements.
  - A digit at 0 with a borrow in becomes 9 and borrows from the next digit.
- Terminal state: all digits 9 when counting up; all digits 0 when counting down.
- eu = ei & ~load & ~reset & terminal(q, up). It is purely combinational, with no register between q and eu.
- At the terminal state with ei=1:
  - SATURATE=0: q wraps (9…9 → 0…0 going up; 0…0 → 9…9 going down).
  - SATURATE=1: q holds its value.
  - In both modes eu=1 for that cycle.
- Reversing direction (toggling up) mid-count is legal and takes effect on the next enabled edge.
- load_err is 0 in every cycle that does not immediately follow a load.
- q never holds a non-BCD digit.

## Timing

- Latency from load or count to q: 1 cycle. q shows the new value after the sampling edge.
- Latency from load to load_err: 1 cycle, aligned with the loaded q.
- eu is valid in the same cycle as ei, up and load; it is intended to drive the ei of the next cascaded instance on the same edge.
- Combinational path: ei → eu is a single AND with a decoded terminal flag; the digit ripple chain does not appear on the eu path.
- Reset asserted mid-count or together with load: q = 0 on the next cycle. Any load or count in that cycle is discarded.
- Release of reset: counting may begin on the first edge after reset is deasserted.

## Structure

- Shared header b10_defs.vh holds:
  - B10_DIGIT_W = 4
  - B10_MAX = 4'd9
  - B10_MIN = 4'd0
- Sub-module b10_updown_digit:
  - One BCD digit register with ci (carry/borrow in), up, load, d, q, co, at_lim.
  - at_lim means the digit is 9 going up or 0 going down.
  - Instantiated N_DIGITS times in a generate loop.
  - ci of digit k = ei & at_lim of all lower digits.
- Top level:
  - Computes terminal = AND of all at_lim.
  - Applies SATURATE gating: suppresses all digit updates when terminal & ei & SATURATE.
  - Registers load_err.

## Test plan

All scenarios use N_DIGITS=4.

- Count up: reset, then ei=1, up=1 for 12 cycles → q=0x0012, eu=0 throughout.
- Carry ripple: load d=0x0999, then ei=1, up=1 for one cycle → q=0x1000 next cycle, eu=0.
- Up limit: load 0x9999, then ei=1, up=1 → eu=1 in that cycle. Next q=0x0000 (SATURATE=0) or q=0x9999 (SATURATE=1).
- Down limit: from reset q=0x0000, ei=1, up=0 → eu=1. Next q=0x9999 (SATURATE=0) or q=0x0000 (SATURATE=1).
- Invalid load: load d=0x12A4 → q=0x1204 and load_err=1 for exactly one cycle, then load_err=0.
- Priority: with q=0x0050, assert load (d=0x0007) and ei together → q=0x0007. Then assert reset, load and ei together → q=0x0000, load_err=0.

Source files
------------

// File: rtl/nd_b10_updown_counter_pkg.sv
// Shared BCD digit definitions and helpers for the N-digit up/down counter.
package nd_b10_updown_counter_pkg;

    localparam int unsigned B10_DIGIT_W    = 4;
    localparam int unsigned B10_DIGITS_MAX = 8;

    typedef logic [B10_DIGIT_W-1:0] b10_digit_t;

    localparam b10_digit_t B10_MAX = 4'd9;
    localparam b10_digit_t B10_MIN = 4'd0;

    // True when the nibble is a legal BCD digit.
    function automatic logic b10_is_valid(input b10_digit_t v);
        return (v <= B10_MAX);
    endfunction

    // Legal digits pass through; illegal ones collapse to zero.
    function automatic b10_digit_t b10_sanitize(input b10_digit_t v);
        return b10_is_valid(v) ? v : B10_MIN;
    endfunction

endpackage

// File: rtl/nd_b10_updown_counter_digit.sv
// One BCD digit of the up/down counter: register, step logic and limit decode.
module b10_updown_digit
    import nd_b10_updown_counter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       ci,
    input  logic       up,
    input  logic       load,
    input  b10_digit_t d,
    output b10_digit_t q,
    output logic       co,
    output logic       at_lim
);

    b10_digit_t r_q;
    b10_digit_t w_q_step;

    // Value this digit takes when it steps in the current direction.
    always_comb begin
        w_q_step = r_q;
        if (up) begin
            w_q_step = (r_q >= B10_MAX) ? B10_MIN : B10_DIGIT_W'(r_q + 1'b1);
        end else begin
            w_q_step = (r_q == B10_MIN) ? B10_MAX : B10_DIGIT_W'(r_q - 1'b1);
        end
    end

    // Digit register: reset, then load, then step on carry/borrow in.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= B10_MIN;
        end else if (load) begin
            r_q <= b10_sanitize(d);
        end else if (ci) begin
            r_q <= w_q_step;
        end
    end

    assign at_lim = up ? (r_q == B10_MAX) : (r_q == B10_MIN);
    assign co     = ci & at_lim;
    assign q      = r_q;

endmodule

// File: rtl/nd_b10_updown_counter.sv
// N-digit BCD up/down counter with parallel load, wrap/saturate limits and cascade output.
module nd_b10_updown_counter
    import nd_b10_updown_counter_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned SATURATE = 0
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            ei,
    input  logic                            up,
    input  logic                            load,
    input  logic [B10_DIGIT_W*N_DIGITS-1:0] d,
    output logic [B10_DIGIT_W*N_DIGITS-1:0] q,
    output logic                            eu,
    output logic                            load_err
);

    localparam bit SAT_EN = (SATURATE != 0);

    if ((N_DIGITS < 1) || (N_DIGITS > B10_DIGITS_MAX)) begin : g_bad_n_digits
        $error("nd_b10_updown_counter: N_DIGITS must be 1..8");
    end

    logic [N_DIGITS-1:0] w_at_lim;
    logic [N_DIGITS-1:0] w_digit_bad;
    logic [N_DIGITS:0]   w_carry;
    logic                w_terminal;
    logic                w_sat_hold;
    logic                w_count_en;
    logic                w_load_bad;
    logic                w_unused_carry_out;
    logic                r_load_err;

    // Terminal decode is a flat AND of per-digit limits, so eu never sees the ripple chain.
    assign w_terminal = &w_at_lim;
    assign w_sat_hold = SAT_EN & ei & w_terminal;
    assign w_count_en = ei & ~w_sat_hold & ~load & ~reset;
    assign w_carry[0] = w_count_en;

    assign eu = ei & ~load & ~reset & w_terminal;

    // Carry/borrow out of the top digit is redundant with eu and intentionally left unused.
    assign w_unused_carry_out = w_carry[N_DIGITS];

    // Digit slices chained by carry/borrow.
    for (genvar gk = 0; gk < N_DIGITS; gk++) begin : g_digit
        b10_updown_digit u_digit (
            .clock  (clock),
            .reset  (reset),
            .ci     (w_carry[gk]),
            .up     (up),
            .load   (load),
            .d      (d[gk*B10_DIGIT_W +: B10_DIGIT_W]),
            .q      (q[gk*B10_DIGIT_W +: B10_DIGIT_W]),
            .co     (w_carry[gk+1]),
            .at_lim (w_at_lim[gk])
        );
        assign w_digit_bad[gk] = ~b10_is_valid(d[gk*B10_DIGIT_W +: B10_DIGIT_W]);
    end

    assign w_load_bad = |w_digit_bad;

    // Load error flag: set for the cycle after a load carrying any non-BCD digit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= load & w_load_bad;
        end
    end

    assign load_err = r_load_err;

endmodule

// File: tb/tb_nd_b10_updown_counter.sv
// Directed table-driven bench for nd_b10_updown_counter, wrap and saturate builds side by side.
module tb_nd_b10_updown_counter;

    logic        clock;
    logic        reset;
    logic        ei;
    logic        up;
    logic        load;
    logic [15:0] d;
    logic [15:0] q_w;
    logic [15:0] q_s;
    logic        eu_w;
    logic        eu_s;
    logic        err_w;
    logic        err_s;

    int n_pass;
    int n_total;

    nd_b10_updown_counter #(.N_DIGITS(4), .SATURATE(0)) dut_wrap (
        .clock    (clock),
        .reset    (reset),
        .ei       (ei),
        .up       (up),
        .load     (load),
        .d        (d),
        .q        (q_w),
        .eu       (eu_w),
        .load_err (err_w)
    );

    nd_b10_updown_counter #(.N_DIGITS(4), .SATURATE(1)) dut_sat (
        .clock    (clock),
        .reset    (reset),
        .ei       (ei),
        .up       (up),
        .load     (load),
        .d        (d),
        .q        (q_s),
        .eu       (eu_s),
        .load_err (err_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        rst;
        logic        ld;
        logic        en;
        logic        dir;
        logic [15:0] din;
        logic        eu_w;
        logic        eu_s;
        logic [15:0] q_w;
        logic [15:0] q_s;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic ld, input logic en, input logic dir,
                         input logic [15:0] din);
        @(negedge clock);
        reset = rst;
        load  = ld;
        ei    = en;
        up    = dir;
        d     = din;
        #1;
    endtask

    task automatic add(input string nm, input logic rst, input logic ld, input logic en,
                       input logic dir, input logic [15:0] din, input logic euw, input logic eus,
                       input logic [15:0] qw, input logic [15:0] qs, input logic er);
        vec_t v;
        v.name = nm; v.rst = rst; v.ld = ld; v.en = en; v.dir = dir; v.din = din;
        v.eu_w = euw; v.eu_s = eus; v.q_w = qw; v.q_s = qs; v.err = er;
        vecs.push_back(v);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset = 1'b1; load = 1'b0; ei = 1'b0; up = 1'b0; d = 16'h0000;

        //  name           rst ld en up d         euW  euS  qW        qS        err
        add("reset_mask",  1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        add("down_limit",  0, 0, 1, 0, 16'h0000, 1, 1, 16'h9999, 16'h0000, 0);
        add("down_after",  0, 0, 1, 0, 16'h0000, 0, 1, 16'h9998, 16'h0000, 0);
        add("load_0999",   0, 1, 0, 1, 16'h0999, 0, 0, 16'h0999, 16'h0999, 0);
        add("carry_rip",   0, 0, 1, 1, 16'h0000, 0, 0, 16'h1000, 16'h1000, 0);
        add("load_9999",   0, 1, 0, 1, 16'h9999, 0, 0, 16'h9999, 16'h9999, 0);
        add("up_limit",    0, 0, 1, 1, 16'h0000, 1, 1, 16'h0000, 16'h9999, 0);
        add("up_after",    0, 0, 1, 1, 16'h0000, 0, 1, 16'h0001, 16'h9999, 0);
        add("reverse",     0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h9998, 0);
        add("hold_ei0",    0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h9998, 0);
        add("load_12A4",   0, 1, 0, 0, 16'h12A4, 0, 0, 16'h1204, 16'h1204, 1);
        add("err_clear",   0, 0, 0, 0, 16'h0000, 0, 0, 16'h1204, 16'h1204, 0);
        add("load_0050",   0, 1, 0, 1, 16'h0050, 0, 0, 16'h0050, 16'h0050, 0);
        add("load_vs_ei",  0, 1, 1, 1, 16'h0007, 0, 0, 16'h0007, 16'h0007, 0);
        add("rst_ld_ei",   1, 1, 1, 1, 16'hABCD, 0, 0, 16'h0000, 16'h0000, 0);
        add("load_F9F9",   0, 1, 0, 1, 16'hF9F9, 0, 0, 16'h0909, 16'h0909, 1);
        add("load_after",  0, 1, 0, 1, 16'h9999, 0, 0, 16'h9999, 16'h9999, 0);
        add("ld_at_term",  0, 1, 1, 1, 16'h0001, 0, 0, 16'h0001, 16'h0001, 0);

        repeat (2) @(posedge clock);
        #1;
        check("init_q_wrap", q_w, 16'h0000);
        check("init_q_sat", q_s, 16'h0000);
        check("init_err", {14'd0, err_w, err_s}, 16'h0000);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].dir, vecs[i].din);
            check({vecs[i].name, ".eu_wrap"}, {15'd0, eu_w}, {15'd0, vecs[i].eu_w});
            check({vecs[i].name, ".eu_sat"}, {15'd0, eu_s}, {15'd0, vecs[i].eu_s});
            @(posedge clock);
            #1;
            check({vecs[i].name, ".q_wrap"}, q_w, vecs[i].q_w);
            check({vecs[i].name, ".q_sat"}, q_s, vecs[i].q_s);
            check({vecs[i].name, ".err_wrap"}, {15'd0, err_w}, {15'd0, vecs[i].err});
            check({vecs[i].name, ".err_sat"}, {15'd0, err_s}, {15'd0, vecs[i].err});
        end

        // Count up twelve times from reset; no terminal state is reached on the way.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        @(posedge clock);
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
            check($sformatf("cnt12.eu_wrap[%0d]", c), {15'd0, eu_w}, 16'h0000);
            check($sformatf("cnt12.eu_sat[%0d]", c), {15'd0, eu_s}, 16'h0000);
            @(posedge clock);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        check("cnt12.q_wrap", q_w, 16'h0012);
        check("cnt12.q_sat", q_s, 16'h0012);

        // Three decrements cross a digit boundary with a borrow: 0012 -> 0009.
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
            @(posedge clock);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        check("borrow.q_wrap", q_w, 16'h0009);
        check("borrow.q_sat", q_s, 16'h0009);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
